// File: rtl/timer_apb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_apb_pkg : FSM state type and timer register offsets          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package timer_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam logic [11:0] TCR   = 12'h000;
  localparam logic [11:0] TDR0  = 12'h004;
  localparam logic [11:0] TDR1  = 12'h008;
  localparam logic [11:0] TCMP0 = 12'h00C;
  localparam logic [11:0] TCMP1 = 12'h010;
  localparam logic [11:0] TIER  = 12'h014;
  localparam logic [11:0] TISR  = 12'h018;
  localparam logic [11:0] THCSR = 12'h01C;

endpackage
`default_nettype wire

// File: rtl/timer_apb_wdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_apb_wdog : APB wait-state counter with expiry flag           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module timer_apb_wdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] C_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expires during the TIMEOUT_CYC-th stalled ACCESS cycle so the abort lands on the next edge.
  assign o_expired = (TIMEOUT_CYC != 0) && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/timer_apb_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_apb_master : command/response stream to APB requester        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module timer_apb_master
  import timer_apb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              tim_psel,
  output logic              tim_penable,
  output logic              tim_pwrite,
  output logic [ADDR_W-1:0] tim_paddr,
  output logic [31:0]       tim_pwdata,
  output logic [3:0]        tim_pstrb,
  input  logic              tim_pready,
  input  logic              tim_pslverr,
  input  logic [31:0]       tim_prdata
);

  apb_state_t        r_state;
  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [31:0]       r_pwdata;
  logic [3:0]        r_pstrb;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic              w_expired;

  timer_apb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .i_clear   (r_state != ACCESS),
    .i_enable  ((r_state == ACCESS) && !tim_pready),
    .o_expired (w_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (cmd_addr[1:0] != 2'b00) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state  <= SETUP;
              r_psel   <= 1'b1;
              r_pwrite <= cmd_write;
              r_paddr  <= cmd_addr;
              r_pwdata <= cmd_wdata;
              r_pstrb  <= cmd_write ? cmd_strb : 4'h0;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          // A ready completer wins over an expiring counter in the same cycle.
          if (tim_pready || w_expired) begin
            r_state     <= RESP;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b1;
            if (tim_pready) begin
              r_rsp_rdata <= (!r_pwrite && !tim_pslverr) ? tim_prdata : 32'h0;
              r_rsp_err   <= tim_pslverr;
            end else begin
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state       <= IDLE;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign tim_psel    = r_psel;
  assign tim_penable = r_penable;
  assign tim_pwrite  = r_pwrite;
  assign tim_paddr   = r_paddr;
  assign tim_pwdata  = r_pwdata;
  assign tim_pstrb   = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_timer_apb_master : directed bench for timer_apb_master          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_timer_apb_master;
  import timer_apb_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic        tim_pready, tim_pslverr;
  logic [31:0] tim_prdata;

  int n_chk = 0;
  int n_bad = 0;
  int cyc, n_en;
  logic psel_seen, hold_bad, setup_ok;

  always #5 sys_clk = ~sys_clk;

  timer_apb_master #(.ADDR_W(12), .TIMEOUT_CYC(16)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .tim_psel    (tim_psel),
    .tim_penable (tim_penable),
    .tim_pwrite  (tim_pwrite),
    .tim_paddr   (tim_paddr),
    .tim_pwdata  (tim_pwdata),
    .tim_pstrb   (tim_pstrb),
    .tim_pready  (tim_pready),
    .tim_pslverr (tim_pslverr),
    .tim_prdata  (tim_prdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue one command and act as an APB completer inserting 'waits' stalled ACCESS cycles.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int waits, input logic [31:0] rd,
                      input logic serr);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    tim_pready = 1'b0; tim_prdata = 32'h0; tim_pslverr = 1'b0;
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    cyc = 1; n_en = 0; psel_seen = 1'b0; hold_bad = 1'b0; setup_ok = 1'b0;
    while (!rsp_valid && cyc < 200) begin
      if (tim_psel) begin
        psel_seen = 1'b1;
        if (tim_paddr !== addr || tim_pwrite !== wr || tim_pstrb !== (wr ? st : 4'h0) ||
            (wr && tim_pwdata !== wd))
          hold_bad = 1'b1;
        if (cyc == 1 && !tim_penable) setup_ok = 1'b1;
        if (tim_penable) begin
          n_en++;
          tim_pready = (n_en > waits);
          tim_prdata  = tim_pready ? rd : 32'hDEAD_BEEF;
          tim_pslverr = tim_pready ? serr : 1'b1;
        end
      end
      tick();
      cyc++;
    end
    tim_pready = 1'b0; tim_prdata = 32'h0; tim_pslverr = 1'b0;
    chk("rsp_seen", rsp_valid, 1'b1);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick();
    chk({tag, "_ready_after"}, cmd_ready, 1'b1);
    chk({tag, "_rsp_cleared"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b1; tim_pready = 1'b0; tim_pslverr = 1'b0; tim_prdata = '0;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_psel", tim_psel, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_paddr", {20'h0, tim_paddr}, 32'h0);
    sys_rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write to TCMP0
    xfer(1'b1, TCMP0, 32'h0000_00FF, 4'hF, 0, 32'h0, 1'b0);
    chk("t1_setup", setup_ok, 1'b1);
    chk("t1_cyc", cyc, 3);
    chk("t1_nen", n_en, 1);
    chk("t1_hold", hold_bad, 1'b0);
    chk("t1_err", rsp_err, 1'b0);
    chk("t1_rdata", rsp_rdata, 32'h0);
    chk("t1_psel_off", tim_psel, 1'b0);
    consume("t1");

    // Read TISR with 3 wait states; pstrb must stay 0
    xfer(1'b0, TISR, 32'h0, 4'hF, 3, 32'h1, 1'b0);
    chk("t2_nen", n_en, 4);
    chk("t2_cyc", cyc, 6);
    chk("t2_hold", hold_bad, 1'b0);
    chk("t2_rdata", rsp_rdata, 32'h1);
    chk("t2_err", rsp_err, 1'b0);
    consume("t2");

    // Write TCR answered with pslverr
    xfer(1'b1, TCR, 32'h0000_A5A5, 4'h3, 0, 32'hFFFF_FFFF, 1'b1);
    chk("t3_err", rsp_err, 1'b1);
    chk("t3_tmo", rsp_timeout, 1'b0);
    chk("t3_rdata", rsp_rdata, 32'h0);
    consume("t3");

    // pready on the last allowed cycle completes normally
    xfer(1'b0, TDR1, 32'h0, 4'h0, 15, 32'h77, 1'b0);
    chk("t4_nen", n_en, 16);
    chk("t4_cyc", cyc, 18);
    chk("t4_tmo", rsp_timeout, 1'b0);
    chk("t4_rdata", rsp_rdata, 32'h77);
    consume("t4");

    // Timeout after 16 stalled ACCESS cycles; late pready ignored
    rsp_ready = 1'b0;
    xfer(1'b0, THCSR, 32'h0, 4'h0, 1000, 32'h55, 1'b0);
    chk("t5_nen", n_en, 16);
    chk("t5_cyc", cyc, 18);
    chk("t5_err", rsp_err, 1'b1);
    chk("t5_tmo", rsp_timeout, 1'b1);
    chk("t5_rdata", rsp_rdata, 32'h0);
    tim_pready = 1'b1; tim_prdata = 32'h55;
    tick();
    chk("t5_late_valid", rsp_valid, 1'b1);
    chk("t5_late_rdata", rsp_rdata, 32'h0);
    chk("t5_late_tmo", rsp_timeout, 1'b1);
    chk("t5_late_psel", tim_psel, 1'b0);
    tim_pready = 1'b0; tim_prdata = 32'h0;
    consume("t5");

    // Misaligned address: no APB transfer
    xfer(1'b1, 12'h00E, 32'h1234, 4'hF, 0, 32'h0, 1'b0);
    chk("t6_psel_seen", psel_seen, 1'b0);
    chk("t6_cyc", cyc, 1);
    chk("t6_err", rsp_err, 1'b1);
    chk("t6_tmo", rsp_timeout, 1'b0);
    consume("t6");

    // Back-pressured response stays stable
    rsp_ready = 1'b0;
    xfer(1'b0, TDR0, 32'h0, 4'h0, 0, 32'h123, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t7_valid", rsp_valid, 1'b1);
      chk("t7_rdata", rsp_rdata, 32'h123);
      chk("t7_cmd_ready", cmd_ready, 1'b0);
    end
    consume("t7");

    // Reset in the middle of ACCESS
    tim_pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = TDR1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t8_penable", tim_penable, 1'b1);
    sys_rst = 1'b1;
    tick();
    chk("t8_psel", tim_psel, 1'b0);
    chk("t8_penable_off", tim_penable, 1'b0);
    chk("t8_rsp_valid", rsp_valid, 1'b0);
    chk("t8_cmd_ready", cmd_ready, 1'b0);
    sys_rst = 1'b0;
    tick();
    chk("t8_ready_back", cmd_ready, 1'b1);
    tick();
    chk("t8_no_rsp", rsp_valid, 1'b0);
    chk("t8_no_psel", tim_psel, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_apb_master.md
# timer_apb_master

APB requester that drives the timer's register interface from a simple command/response stream. It sits between firmware-side control logic (or an SoC fabric adapter) and the timer's APB completer port. It turns each accepted command into exactly one APB read or write transfer to offsets TCR..THCSR and returns read data and error status. It also bounds completer wait states with a timeout.

## Interface
- ADDR_W, 12, APB address width (timer offset space 0x000–0xFFF)
- TIMEOUT_CYC, 256, max ACCESS cycles with pready low before abort; 0 disables timeout
- sys_clk  in  1  sole clock; all logic rising-edge
- sys_rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  32  write data
- cmd_strb  in  4  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_rdata  out  32  read data (0 for writes, errors, timeouts)
- rsp_err  out  1  pslverr, misalignment or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- tim_psel, tim_penable, tim_pwrite  out  1  APB control
- tim_paddr  out  ADDR_W  APB address
- tim_pwdata  out  32  APB write data
- tim_pstrb  out  4  APB strobes
- tim_pready, tim_pslverr  in  1  APB completer status
- tim_prdata  in  32  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On handshake, latch write/addr/wdata/strb.
  - If addr[1:0]≠0, go to RESP with err=1 and no APB transfer.
  - Otherwise go to SETUP.
- SETUP: psel=1, penable=0, and address/control/data valid. Always go to ACCESS next cycle.
- ACCESS: psel=1, penable=1.
  - If pready=1, capture prdata (reads only) and pslverr, then go to RESP.
  - If pready=0, increment the wait counter.
  - When the counter reaches TIMEOUT_CYC (and TIMEOUT_CYC≠0), drop psel/penable and go to RESP with err=1, timeout=1, rdata=0.
- RESP: rsp_valid=1 with stable rdata/err/timeout. On rsp_ready, go to IDLE.
- cmd_ready is only asserted in IDLE. No command is accepted while a response is outstanding.
- APB signals:
  - paddr, pwrite, pwdata and pstrb are held constant from SETUP through the last ACCESS cycle.
  - pstrb=0 for reads.
  - Outside SETUP/ACCESS: psel=penable=0, and paddr/pwdata/pstrb are driven to 0.
- The wait counter clears on entry to SETUP. It is sized $clog2(TIMEOUT_CYC+1), minimum 1 bit.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from cmd_* or tim_* to outputs.
- Zero-wait-state transfer:
  - cycle 0: cmd handshake
  - cycle 1: SETUP
  - cycle 2: ACCESS with pready=1
  - cycle 3: rsp_valid=1
- Each pready-low cycle in ACCESS adds 1 cycle.
- Throughput with rsp_ready held high: one command per 4 cycles.
- Misaligned command: rsp_valid in the cycle after the handshake; psel never asserts.
- Timeout: after TIMEOUT_CYC ACCESS cycles with pready low, rsp_valid asserts on the following cycle. A pready arriving after the abort is ignored.
- pready=1 on the same cycle the counter reaches its limit: normal completion wins, timeout=0.
- Reset values: cmd_ready=0 while sys_rst=1, and 1 from the first cycle after release. All other outputs are 0.
- Reset mid-transfer: psel/penable are 0 on the next edge, the pending command and response are discarded, and no response is issued.

## Structure
- Package timer_apb_pkg:
  - FSM state enum.
  - Timer offset constants: TCR 0x00, TDR0 0x04, TDR1 0x08, TCMP0 0x0C, TCMP1 0x10, TIER 0x14, TISR 0x18, THCSR 0x1C.
- One sub-module, timer_apb_wdog: the wait-state counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYC.

## Test plan
- Write TCMP0=0x000000FF with strb 0xF and a zero-wait completer → SETUP at cycle 1, ACCESS at 2, rsp_valid at 3. paddr=0x00C, pwdata=0xFF, pstrb=0xF; rsp_err=0.
- Read TISR with the completer returning 0x1 after 3 wait states → penable high for 4 cycles; rsp_rdata=0x1, rsp_err=0; pstrb=0 throughout.
- Write TCR with pslverr=1 on completion → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT_CYC=16 and pready held low → psel drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; a later pready is ignored.
- Command to addr 0x00E → no psel; rsp_valid on the next cycle with rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after a read of TDR0=0x123 → rsp stable with rdata=0x123 and cmd_ready=0; sys_rst pulsed mid-ACCESS → psel=0 and rsp_valid=0 on the next edge.
